// File: rtl/sprite_arb_pkg.sv
// Shared types and default sizing for the sprite ROM arbiter.
package sprite_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ADDR_W    = 14;
    localparam int DEF_DATA_W    = 4;
    localparam int DEF_ROM_LAT   = 2;
    localparam int DEF_BURST_MAX = 16;

    // Index width for a requester vector; never zero, even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit after last_winner, wrapping.
// The previous winner is naturally searched last, so it only wins when alone.
module sprite_arb_rr_pick
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] cand;

    // Walk candidates last_winner+1 .. last_winner+NUM_REQ, keep the first hit.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_winner) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM read-port arbiter: round-robin grants with optional locked bursts,
// plus a gnt tag pipeline that names the owner of each returning ROM word.
// Optional build macro SPRITE_ARB_PRIORITY_EN: requester 0 preempts and always
// wins arbitration without disturbing the round-robin pointer.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ROM_LAT   = DEF_ROM_LAT,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic                           vga_clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             lock,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [ADDR_W-1:0]              rom_address,
    input  logic [DATA_W-1:0]              rom_q,
    output logic [DATA_W-1:0]              rdata,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic                           busy
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_t                        state;
    logic [IDX_W-1:0]                  last_winner;
    logic [IDX_W-1:0]                  owner;
    logic [CNT_W-1:0]                  burst_cnt;
    // Stage 0 is the live grant; stage ROM_LAT lines up with rom_q.
    logic [ROM_LAT:0][NUM_REQ-1:0]     vld_pipe;
    logic [DATA_W-1:0]                 rdata_q;

    logic                              rr_found;
    logic [IDX_W-1:0]                  rr_winner;
    logic                              arb_found;
    logic [IDX_W-1:0]                  arb_idx;
    logic                              arb_rr;
    logic                              keep;

    sprite_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req         (req),
        .last_winner (last_winner),
        .found       (rr_found),
        .winner      (rr_winner)
    );

`ifdef SPRITE_ARB_PRIORITY_EN
    // Requester 0 overrides the round-robin result and leaves the pointer alone.
    assign arb_found = req[0] | rr_found;
    assign arb_idx   = req[0] ? '0 : rr_winner;
    assign arb_rr    = !req[0];
    assign keep      = (state == OWNED) && req[owner] && lock[owner] &&
                       (burst_cnt < CNT_W'(BURST_MAX)) && !(req[0] && (owner != '0));
`else
    assign arb_found = rr_found;
    assign arb_idx   = rr_winner;
    assign arb_rr    = 1'b1;
    assign keep      = (state == OWNED) && req[owner] && lock[owner] &&
                       (burst_cnt < CNT_W'(BURST_MAX));
`endif

    assign gnt    = vld_pipe[0];
    assign rvalid = vld_pipe[ROM_LAT];
    assign busy   = (state == OWNED);
    // Show rom_q while a tagged word is returning, otherwise the last returned word.
    assign rdata  = (|rvalid) ? rom_q : rdata_q;

    // Arbitration FSM, grant/address registers and the return tag pipeline.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_winner <= IDX_W'(NUM_REQ - 1);
            owner       <= '0;
            burst_cnt   <= '0;
            rom_address <= '0;
            vld_pipe    <= '0;
            rdata_q     <= '0;
        end else begin
            for (int k = 1; k <= ROM_LAT; k++)
                vld_pipe[k] <= vld_pipe[k-1];
            if (|rvalid)
                rdata_q <= rom_q;

            if (keep) begin
                rom_address <= addr[owner];
                burst_cnt   <= burst_cnt + CNT_W'(1);
            end else if (arb_found) begin
                state       <= OWNED;
                vld_pipe[0] <= NUM_REQ'(1) << arb_idx;
                rom_address <= addr[arb_idx];
                owner       <= arb_idx;
                burst_cnt   <= CNT_W'(1);
                if (arb_rr)
                    last_winner <= arb_idx;
            end else begin
                state       <= IDLE;
                vld_pipe[0] <= '0;
                burst_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios plus random
// traffic compared against a cycle-level behavioural model of the arbiter.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 4;
    localparam int ROM_LAT   = 2;
    localparam int BURST_MAX = 16;

    logic                           vga_clk = 1'b0;
    logic                           reset_n = 1'b0;
    logic [NUM_REQ-1:0]             req     = '0;
    logic [NUM_REQ-1:0]             lock    = '0;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr    = '0;
    logic [DATA_W-1:0]              rom_q   = '0;
    logic [NUM_REQ-1:0]             gnt;
    logic [ADDR_W-1:0]              rom_address;
    logic [DATA_W-1:0]              rdata;
    logic [NUM_REQ-1:0]             rvalid;
    logic                           busy;

    int errors = 0;
    int checks = 0;

    // Reference model state: owner (-1 when idle), burst length, RR pointer,
    // grant history (index 0 = current gnt, index ROM_LAT = expected rvalid).
    int                 m_owner = -1;
    int                 m_cnt   = 0;
    int                 m_last  = NUM_REQ - 1;
    logic [ADDR_W-1:0]  m_addr  = '0;
    logic [DATA_W-1:0]  m_held  = '0;
    logic [NUM_REQ-1:0] m_hist[$];

    sprite_rom_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ROM_LAT   (ROM_LAT),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .req         (req),
        .lock        (lock),
        .addr        (addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic model_edge();
        logic [NUM_REQ-1:0] g;
        int  w;
        bit  prio_win;
        bit  hold;
        if (m_hist[ROM_LAT] != '0)
            m_held = rom_q;
        if (!reset_n) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = NUM_REQ - 1;
            m_addr  = '0;
            m_held  = '0;
            foreach (m_hist[k]) m_hist[k] = '0;
            return;
        end
        hold = (m_owner >= 0) && req[m_owner] && lock[m_owner] && (m_cnt < BURST_MAX);
`ifdef SPRITE_ARB_PRIORITY_EN
        if (m_owner > 0 && req[0]) hold = 1'b0;
`endif
        g = '0;
        if (hold) begin
            m_cnt++;
            m_addr = addr[m_owner];
            g = NUM_REQ'(1 << m_owner);
        end else begin
            w = -1;
            prio_win = 1'b0;
`ifdef SPRITE_ARB_PRIORITY_EN
            if (req[0]) begin
                w = 0;
                prio_win = 1'b1;
            end
`endif
            for (int i = 1; i <= NUM_REQ && w < 0; i++)
                if (req[(m_last + i) % NUM_REQ]) w = (m_last + i) % NUM_REQ;
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 1;
                m_addr  = addr[w];
                if (!prio_win) m_last = w;
                g = NUM_REQ'(1 << w);
            end else begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        m_hist.push_front(g);
        void'(m_hist.pop_back());
    endtask

    // One clock: update model at the edge, present a new ROM word, compare everything.
    task automatic step();
        logic [DATA_W-1:0] exp_rdata;
        @(posedge vga_clk);
        model_edge();
        #1;
        rom_q = DATA_W'($urandom);
        #1;
        exp_rdata = (m_hist[ROM_LAT] != '0) ? rom_q : m_held;
        chk("gnt",         32'(gnt),         32'(m_hist[0]));
        chk("rom_address", 32'(rom_address), 32'(m_addr));
        chk("rvalid",      32'(rvalid),      32'(m_hist[ROM_LAT]));
        chk("rdata",       32'(rdata),       32'(exp_rdata));
        chk("busy",        32'(busy),        32'(m_owner >= 0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k <= ROM_LAT; k++) m_hist.push_back('0);

        // Reset state
        reset_n = 1'b0;
        step();
        step();
        chk("rst_gnt",    32'(gnt),         32'h0);
        chk("rst_rvalid", 32'(rvalid),      32'h0);
        chk("rst_rdata",  32'(rdata),       32'h0);
        chk("rst_addr",   32'(rom_address), 32'h0);
        chk("rst_busy",   32'(busy),        32'h0);

        // Single unlocked read from requester 0
        reset_n = 1'b1;
        req     = 4'b0001;
        addr[0] = 14'h0123;
        step();
        chk("single_gnt",  32'(gnt),         32'h1);
        chk("single_addr", 32'(rom_address), 32'h0123);
        req = 4'b0000;
        step();
        step();
        chk("single_rvalid", 32'(rvalid), 32'h1);
        chk("single_rdata",  32'(rdata),  32'(rom_q));

        // All four requesting, unlocked: pure rotation, returns two cycles later
        do_reset();
        req  = 4'b1111;
        lock = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            if (k >= ROM_LAT)
                chk("rr_rvalid", 32'(rvalid), 32'(1 << ((k - ROM_LAT) % 4)));
        end

        // Locked burst by requester 1 capped at BURST_MAX, then requester 0
        do_reset();
        req  = 4'b0011;
        lock = 4'b0010;
        step();
        chk("burst_first", 32'(gnt), 32'h1);
        for (int k = 0; k < BURST_MAX; k++) begin
            step();
            chk("burst_hold", 32'(gnt), 32'h2);
        end
        step();
        chk("burst_end", 32'(gnt), 32'h1);

        // Reset in the middle of a locked burst flushes the return path
        do_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush_burst", 32'(gnt), 32'h4);
        end
        reset_n = 1'b0;
        step();
        chk("flush_gnt",    32'(gnt),    32'h0);
        chk("flush_rvalid", 32'(rvalid), 32'h0);
        reset_n = 1'b1;
        req  = 4'b0000;
        lock = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("flush_quiet", 32'(rvalid), 32'h0);
        end

        // Requester 0 rises during requester 3's locked burst
        do_reset();
        req  = 4'b1000;
        lock = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("pre_burst", 32'(gnt), 32'h8);
        end
        req = 4'b1001;
        step();
`ifdef SPRITE_ARB_PRIORITY_EN
        chk("preempt", 32'(gnt), 32'h1);
`else
        chk("no_preempt", 32'(gnt), 32'h8);
        for (int k = 4; k < BURST_MAX; k++) begin
            step();
            chk("no_preempt_hold", 32'(gnt), 32'h8);
        end
        step();
        chk("no_preempt_end", 32'(gnt), 32'h1);
`endif

        // Random traffic against the model
        reset_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            reset_n = ($urandom_range(63) != 0);
            req     = NUM_REQ'($urandom);
            lock    = ($urandom_range(3) != 0) ? 4'b1111 : NUM_REQ'($urandom);
            for (int k = 0; k < NUM_REQ; k++) addr[k] = ADDR_W'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of sprite requesters sharing one sprite ROM read port.
REQ-002 Parameter ADDR_W, default 14, ROM address width.
REQ-003 Parameter DATA_W, default 4, ROM palette-index width.
REQ-004 Parameter ROM_LAT, default 2, cycles from rom_address registered to rom_q valid; legal range 1..4.
REQ-005 Parameter BURST_MAX, default 16, maximum consecutive grants to one locked owner.
REQ-006 vga_clk  in  1  sole clock; all state updates on posedge.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 req  in  NUM_REQ  per-requester read request, level.
REQ-009 lock  in  NUM_REQ  per-requester burst-hold request, sampled with req.
REQ-010 addr  in  NUM_REQ x ADDR_W  per-requester ROM address.
REQ-011 gnt  out  NUM_REQ  registered one-hot grant, at most one bit set.
REQ-012 rom_address  out  ADDR_W  registered address to the ROM.
REQ-013 rom_q  in  DATA_W  ROM read data.
REQ-014 rdata  out  DATA_W  returned palette index.
REQ-015 rvalid  out  NUM_REQ  one-hot return strobe naming the owner of rdata.
REQ-016 busy  out  1  high while the FSM is OWNED.

Function
REQ-017 FSM SHALL have exactly two states, IDLE and OWNED.
REQ-018 Arbitration point: every cycle in IDLE; in OWNED, any cycle where the current owner's burst ends.
REQ-019 Round-robin: at an arbitration point, the winner SHALL be the first requester with req set, searching from last_winner+1 with wrap-around modulo NUM_REQ.
REQ-020 Winner found: next cycle gnt = one-hot(winner), rom_address = addr[winner], last_winner = winner, burst_cnt = 1, state = OWNED; no winner: gnt = 0, state = IDLE.
REQ-021 OWNED, owner has req and lock set, and burst_cnt < BURST_MAX: owner SHALL keep gnt, rom_address SHALL follow addr[owner], burst_cnt increments.
REQ-022 OWNED, owner drops req or lock, or burst_cnt = BURST_MAX: that cycle is an arbitration point per REQ-019; the owner is eligible only if no other requester is pending.
REQ-023 An unlocked grant SHALL last exactly one cycle.
REQ-024 Return path: rvalid SHALL equal gnt delayed exactly ROM_LAT cycles; in the same cycle rdata SHALL equal rom_q. rdata holds its last value while rvalid = 0.
REQ-025 Return path is a tag shift pipeline ROM_LAT deep; back-to-back grants SHALL return back-to-back with no bubbles.
REQ-026 gnt changes only on posedge; addr changes by a non-owner have no effect.

Reset
REQ-027 While reset_n = 0 at posedge: state = IDLE, gnt = 0, rvalid = 0, rdata = 0, rom_address = 0, busy = 0, burst_cnt = 0, last_winner = NUM_REQ-1 (requester 0 wins first).
REQ-028 Reset mid-burst SHALL flush the return pipeline; no rvalid pulse occurs from a grant issued before reset.

Configuration
REQ-029 Macro SPRITE_ARB_PRIORITY_EN.
REQ-030 Defined: req[0] SHALL win every arbitration point it participates in, and req[0] asserted while another requester owns a burst SHALL end that burst, with requester 0 granted next cycle; last_winner is not updated by priority wins.
REQ-031 Undefined: pure round-robin per REQ-019..REQ-022.

Structure
REQ-032 Package sprite_arb_pkg SHALL hold the FSM state enum (IDLE, OWNED) and default parameter constants.
REQ-033 Sub-module sprite_arb_rr_pick: combinational round-robin picker (req, last_winner, outputs found and winner index).

Verification
REQ-034 Reset, req=4'b0001, lock=0, addr[0]=14'h0123 -> gnt=0001 next cycle, rom_address=0123, rvalid=0001 two cycles later with rdata=rom_q.
REQ-035 req=4'b1111, lock=0, held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,..., rvalid identical sequence delayed 2 cycles.
REQ-036 req=4'b0011, lock[1]=1, requester 1 owns -> 16 consecutive gnt=0010, then gnt=0001 for one cycle.
REQ-037 Requester 2 locked burst, reset_n low at burst cycle 3 -> gnt=0 and rvalid=0 next cycle, no rvalid pulse in the following 4 cycles.
REQ-038 SPRITE_ARB_PRIORITY_EN, requester 3 locked burst, req[0] rises -> gnt=0001 next cycle; macro undefined -> burst continues to BURST_MAX.
